// File: rtl/seq_player.sv
// Sequence player: steps an index through a loadable table at a prescaled rate,
// in wrap, ping-pong or one-shot order, and presents the selected entry on oNum.
module seq_player #(
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4,
    parameter int PRESC_W = 8
) (
    input  logic               rClk,
    input  logic               iRst_n,
    input  logic               iEn,
    input  logic               iDir,
    input  logic [1:0]         iMode,
    input  logic [PTR_W:0]     iLen,
    input  logic [PRESC_W-1:0] iPresc,
    input  logic               iClr,
    input  logic               iWr,
    input  logic [PTR_W-1:0]   iWrAddr,
    input  logic [DATA_W-1:0]  iWrData,
    output logic [DATA_W-1:0]  oNum,
    output logic [PTR_W-1:0]   oIdx,
    output logic               oTick,
    output logic               oWrap,
    output logic               oDone
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [1:0]     MODE_PP  = 2'b01;
    localparam logic [1:0]     MODE_ONE = 2'b10;
    localparam logic [PTR_W:0] LEN_MAX  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] LEN_ONE  = (PTR_W + 1)'(1);

    logic [DATA_W-1:0]  tbl_q [DEPTH];
    logic [DATA_W-1:0]  tbl_d [DEPTH];
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  num_q, num_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;
    logic               dir_q, dir_d;
    state_t             state_q, state_d;

    logic [PTR_W:0]     len_eff;
    logic [PTR_W-1:0]   last_idx;
    logic               eff_dir;
    logic               step_en;
    logic               at_end;

    // Length clamp: zero means one entry, anything above DEPTH means DEPTH.
    always_comb begin
        len_eff = iLen;
        if (iLen == '0) begin
            len_eff = LEN_ONE;
        end else if (iLen > LEN_MAX) begin
            len_eff = LEN_MAX;
        end
        last_idx = PTR_W'(len_eff - LEN_ONE);
    end

    // Ping-pong runs on its own direction register; other modes follow iDir.
    assign eff_dir = (iMode == MODE_PP) ? dir_q : iDir;
    assign step_en = iEn && (presc_q == iPresc) && (state_q == ST_RUN);

    always_comb begin
        tbl_d   = tbl_q;
        idx_d   = idx_q;
        num_d   = tbl_q[idx_q];
        presc_d = presc_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        dir_d   = (iMode == MODE_PP) ? dir_q : iDir;
        state_d = state_q;
        at_end  = 1'b0;

        if (iWr) begin
            tbl_d[iWrAddr] = iWrData;
        end

        if (iClr) begin
            idx_d   = iDir ? last_idx : '0;
            presc_d = '0;
            dir_d   = iDir;
            state_d = ST_RUN;
        end else if (step_en) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if ({1'b0, idx_q} >= len_eff) begin
                idx_d = eff_dir ? last_idx : '0;
            end else if (iMode == MODE_PP) begin
                if (len_eff == LEN_ONE) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else if (!dir_q) begin
                    if (idx_q == last_idx) begin
                        dir_d  = 1'b1;
                        idx_d  = last_idx - 1'b1;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    if (idx_q == '0) begin
                        dir_d  = 1'b0;
                        idx_d  = PTR_W'(1);
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end else begin
                at_end = eff_dir ? (idx_q == '0) : (idx_q == last_idx);
                if (at_end) begin
                    wrap_d = 1'b1;
                    if (iMode == MODE_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = eff_dir ? last_idx : '0;
                    end
                end else begin
                    idx_d = eff_dir ? (idx_q - 1'b1) : (idx_q + 1'b1);
                end
            end
        end else if (iEn && (state_q == ST_RUN)) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge rClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
            idx_q   <= '0;
            num_q   <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            dir_q   <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            tbl_q   <= tbl_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            dir_q   <= dir_d;
            state_q <= state_d;
        end
    end

    assign oNum  = num_q;
    assign oIdx  = idx_q;
    assign oTick = tick_q;
    assign oWrap = wrap_q;
    assign oDone = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: wrap, ping-pong, one-shot, enable freeze,
// table write latency and asynchronous reset, against hand-computed values.
module tb_seq_player;

    logic       rClk;
    logic       iRst_n;
    logic       iEn;
    logic       iDir;
    logic [1:0] iMode;
    logic [4:0] iLen;
    logic [7:0] iPresc;
    logic       iClr;
    logic       iWr;
    logic [3:0] iWrAddr;
    logic [3:0] iWrData;
    logic [3:0] oNum;
    logic [3:0] oIdx;
    logic       oTick;
    logic       oWrap;
    logic       oDone;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] tbl [9];
    logic [3:0] pp_idx [8];
    logic       pp_wrap [8];

    seq_player #(
        .DATA_W(4), .DEPTH(16), .PTR_W(4), .PRESC_W(8)
    ) dut (
        .rClk(rClk), .iRst_n(iRst_n), .iEn(iEn), .iDir(iDir), .iMode(iMode),
        .iLen(iLen), .iPresc(iPresc), .iClr(iClr), .iWr(iWr),
        .iWrAddr(iWrAddr), .iWrData(iWrData), .oNum(oNum), .oIdx(oIdx),
        .oTick(oTick), .oWrap(oWrap), .oDone(oDone)
    );

    initial begin
        rClk = 1'b0;
        forever #5 rClk = ~rClk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge rClk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic restart();
        iClr = 1'b1;
        step(1);
        iClr = 1'b0;
    endtask

    initial begin
        tbl     = '{4'd8, 4'd1, 4'd0, 4'd4, 4'd4, 4'd0, 4'd0, 4'd2, 4'd3};
        pp_idx  = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2};
        pp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        iRst_n = 1'b0; iEn = 1'b0; iDir = 1'b0; iMode = 2'b00; iLen = 5'd9;
        iPresc = 8'd0; iClr = 1'b0; iWr = 1'b0; iWrAddr = '0; iWrData = '0;
        #2;
        check("rst_idx", oIdx, 0);
        check("rst_num", oNum, 0);
        check("rst_flags", {oTick, oWrap, oDone}, 0);
        step(2);
        iRst_n = 1'b1;
        step(1);

        // load table with the player held
        for (int i = 0; i < 9; i++) begin
            iWr = 1'b1; iWrAddr = 4'(i); iWrData = tbl[i];
            step(1);
        end
        iWr = 1'b0;

        // wrap up
        iEn = 1'b1;
        restart();
        check("up_clr_idx", oIdx, 0);
        check("up_clr_num", oNum, 8);
        for (int k = 1; k <= 11; k++) begin
            step(1);
            check($sformatf("up_idx%0d", k), oIdx, k % 9);
            check($sformatf("up_num%0d", k), oNum, tbl[(k - 1) % 9]);
            check($sformatf("up_wrap%0d", k), oWrap, (k % 9) == 0);
            check($sformatf("up_tick%0d", k), oTick, 1);
        end

        // wrap down
        iDir = 1'b1;
        restart();
        check("dn_clr_idx", oIdx, 8);
        check("dn_clr_tick", oTick, 0);
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check($sformatf("dn_idx%0d", k), oIdx, (8 - k + 18) % 9);
            check($sformatf("dn_num%0d", k), oNum, tbl[(8 - (k - 1) + 18) % 9]);
            check($sformatf("dn_wrap%0d", k), oWrap, k == 9);
        end

        // ping-pong over 4 entries
        iMode = 2'b01; iLen = 5'd4; iDir = 1'b0;
        restart();
        check("pp_clr_idx", oIdx, 0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            check($sformatf("pp_idx%0d", k), oIdx, pp_idx[k]);
            check($sformatf("pp_wrap%0d", k), oWrap, pp_wrap[k]);
        end
        // shrinking the length leaves idx 2 out of range
        iLen = 5'd1;
        step(1);
        check("pp1_oor_idx", oIdx, 0);
        check("pp1_oor_wrap", oWrap, 0);
        check("pp1_oor_tick", oTick, 1);
        for (int k = 0; k < 2; k++) begin
            step(1);
            check($sformatf("pp1_idx%0d", k), oIdx, 0);
            check($sformatf("pp1_wrap%0d", k), oWrap, 1);
        end

        // one-shot, step every third cycle
        iMode = 2'b10; iLen = 5'd3; iPresc = 8'd2; iDir = 1'b0;
        restart();
        check("os_clr_idx", oIdx, 0);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check($sformatf("os_tick%0d", k), oTick, (k % 3) == 0 && k <= 9);
            check($sformatf("os_idx%0d", k), oIdx, (k < 3) ? 0 : (k < 6) ? 1 : 2);
            check($sformatf("os_done%0d", k), oDone, k >= 9);
            check($sformatf("os_wrap%0d", k), oWrap, k == 9);
        end
        iMode = 2'b00;
        step(3);
        check("os_mode_done", oDone, 1);
        check("os_mode_idx", oIdx, 2);
        restart();
        check("os_clr_done", oDone, 0);
        check("os_clr_idx2", oIdx, 0);

        // enable freeze mid-count
        iLen = 5'd9; iPresc = 8'd2;
        restart();
        step(4);
        check("frz_pre_idx", oIdx, 1);
        iEn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check($sformatf("frz_idx%0d", k), oIdx, 1);
            check($sformatf("frz_tick%0d", k), oTick, 0);
        end
        iEn = 1'b1;
        step(1);
        check("frz_res1_idx", oIdx, 1);
        check("frz_res1_tick", oTick, 0);
        step(1);
        check("frz_res2_idx", oIdx, 2);
        check("frz_res2_tick", oTick, 1);

        // write to the current index
        iEn = 1'b0;
        iWr = 1'b1; iWrAddr = 4'd2; iWrData = 4'd9;
        step(1);
        iWr = 1'b0;
        check("wr_num_same", oNum, 0);
        step(1);
        check("wr_num_next", oNum, 9);

        // async reset mid-run at idx 5
        iEn = 1'b1; iPresc = 8'd0; iLen = 5'd9;
        restart();
        step(5);
        check("ar_pre_idx", oIdx, 5);
        #3;
        iRst_n = 1'b0;
        #1;
        check("ar_idx", oIdx, 0);
        check("ar_num", oNum, 0);
        check("ar_flags", {oTick, oWrap, oDone}, 0);
        #2;
        iRst_n = 1'b1;
        iLen = 5'd16;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check($sformatf("ar_tbl%0d", k - 1), oNum, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Parametrised sequence player. Steps an index through a run-time loadable table of DATA_W-bit values and outputs the selected entry.
- Adds four things to the fixed-sequence hex counter: programmable table contents, programmable length, a step prescaler, and three sequencing modes (wrap, ping-pong, one-shot).
- Drives display/number sinks in the same clock domain.

Parameters:
- DATA_W, 4, width of each table entry and of oNum.
- DEPTH, 16, number of table entries (power of 2, at least 2).
- PTR_W, 4, index width; equals log2(DEPTH).
- PRESC_W, 8, prescaler compare width.

Ports:
- rClk  in  1  clock.
- iRst_n  in  1  reset, asynchronous, active-low.
- iEn  in  1  run enable; 0 holds all state.
- iDir  in  1  direction: 0 = up, 1 = down.
- iMode  in  2  00 = wrap, 01 = ping-pong, 10 = one-shot, 11 = treated as wrap.
- iLen  in  PTR_W+1  active entry count; 0 treated as 1; values above DEPTH clamped to DEPTH. Clamped value is len_eff.
- iPresc  in  PRESC_W  one step every iPresc+1 enabled cycles.
- iClr  in  1  synchronous restart.
- iWr  in  1  table write strobe.
- iWrAddr  in  PTR_W  table write address.
- iWrData  in  DATA_W  table write data.
- oNum  out  DATA_W  current table value.
- oIdx  out  PTR_W  current index.
- oTick  out  1  one-cycle pulse on every index step.
- oWrap  out  1  one-cycle pulse on wrap or ping-pong reversal.
- oDone  out  1  one-shot complete (level).

Behaviour:
- Reset (async, iRst_n=0): all table entries 0, oIdx=0, oNum=0, oTick=0, oWrap=0, oDone=0, prescaler=0, state RUN, internal direction=up. All outputs are registered.
- Table write: when iWr=1, table[iWrAddr] <= iWrData at the rClk edge. Writes are accepted in every state, independent of iEn.
- oNum: oNum <= table[oIdx], reading pre-edge table contents and pre-edge index. oNum therefore lags an index change or a write by exactly 1 cycle.
- Prescaler:
  - tick = iEn && (presc_cnt == iPresc) && state==RUN.
  - On tick, presc_cnt <= 0.
  - Else if iEn && state==RUN, presc_cnt increments.
  - With iEn=0, presc_cnt holds.
  - If iPresc changes below the current presc_cnt, the count runs to all-ones and wraps once. This is accepted; no guard is added.
- Start index: 0 when the effective direction is up, len_eff-1 when down.
- iClr (priority over tick):
  - oIdx <= start index; presc_cnt <= 0; oDone <= 0; state <= RUN.
  - Internal direction <= iDir.
  - oTick=0 and oWrap=0 in that cycle.
- Effective direction: iDir in wrap and one-shot modes; the internal direction register in ping-pong mode. The internal register follows iDir every cycle while iMode is not ping-pong.
- Step on tick, wrap mode:
  - Up: idx==len_eff-1 goes to 0 with oWrap=1; otherwise idx+1.
  - Down: idx==0 goes to len_eff-1 with oWrap=1; otherwise idx-1.
- Step on tick, ping-pong mode:
  - Up at len_eff-1: internal direction <= down, idx <= len_eff-2, oWrap=1.
  - Down at 0: internal direction <= up, idx <= 1, oWrap=1.
  - len_eff==1: idx stays 0, oWrap=1 on every tick.
- Step on tick, one-shot mode:
  - At the end index (len_eff-1 going up, 0 going down): idx holds, oDone <= 1, oWrap=1, state <= DONE.
  - DONE: no ticks. Exit only by iClr or reset.
  - A mode change while in DONE does not exit DONE.
- Out-of-range index (len_eff reduced so that idx >= len_eff): the next tick loads the start index. No oWrap on that step.
- oTick=1 in every cycle in which idx was stepped by a tick. This includes terminal steps that hold idx in one-shot and len_eff==1.
- Direction change mid-run: takes effect on the next tick. No extra cycle.
- Reset mid-operation: returns to reset values immediately. Table contents are lost.

Test Plan:
- Load 8,1,0,4,4,0,0,2,3 at addresses 0..8; iLen=9, iMode=00, iDir=0, iPresc=0, iEn=1 -> oNum sequence 8,1,0,4,4,0,0,2,3,8...; oWrap pulses on the step from idx 8 to 0.
- Same table, iDir=1, pulse iClr -> oIdx starts at 8; oNum 3,2,0,0,4,4,0,1,8,3...; oWrap on the step from 0 to 8.
- iMode=01, iLen=4, iPresc=0 -> oIdx 0,1,2,3,2,1,0,1...; oWrap at idx 3 and idx 0; then iLen=1 -> oIdx stays 0, oWrap every cycle.
- iMode=10, iLen=3, iPresc=2 -> oTick every 3rd cycle; oIdx 0,1,2; oDone=1 after the 3rd tick and stays 1 with iEn=1; iClr -> oDone=0, oIdx=0.
- iEn toggled 0 for 5 cycles mid-count -> oIdx and presc_cnt frozen, resume exactly. iWr to the current index -> new value on oNum 1 cycle later.
- iRst_n asserted asynchronously mid-step at oIdx=5 -> oIdx=0, oNum=0, table all zeros before the next rClk edge.
